// File: rtl/fn1_accum_pkg.sv
// Shared types and default widths for the fn1 product accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fn1_accum_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam int DEF_IN_W      = 31;
   localparam int DEF_ACC_W     = 40;
   localparam int DEF_MAX_TERMS = 256;

   // Width of a counter that must hold the value max_terms itself.
   function automatic int cnt_width(input int max_terms);
      return $clog2(max_terms + 1);
   endfunction

   localparam int DEF_CNT_W = cnt_width(DEF_MAX_TERMS);

endpackage

// File: rtl/fn1_prod_accum_if.sv
// Product-in / sum-out handshake bundle for fn1_prod_accum.
// Latency: n/a (wires only).
// Backpressure: in_ready from the accumulator, out_ready from the consumer.
interface fn1_prod_accum_if
   import fn1_accum_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int ACC_W = DEF_ACC_W,
   parameter int CNT_W = DEF_CNT_W
);
   logic             in_valid;
   logic [IN_W-1:0]  in_data;
   logic             in_last;
   logic             in_ready;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_data;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   modport master (
      output in_valid, in_data, in_last, flush, out_ready,
      input  in_ready, out_valid, out_data, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_data, in_last, flush, out_ready,
      output in_ready, out_valid, out_data, out_count, out_ovf
   );
endinterface

// File: rtl/fn1_accum_out_reg.sv
// One-entry valid/ready holding register for a closed group {sum, count, ovf}.
// Latency: 1 cycle from load_i to valid_o.
// Backpressure: holds contents while valid_o & ~ready_i; a load in the transfer cycle replaces them.
module fn1_accum_out_reg #(
   parameter int ACC_W = 40,
   parameter int CNT_W = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [ACC_W-1:0] data_i,
   input  logic [CNT_W-1:0] count_i,
   input  logic             ovf_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [ACC_W-1:0] data_o,
   output logic [CNT_W-1:0] count_o,
   output logic             ovf_o
);
   logic             valid_q, valid_d;
   logic [ACC_W-1:0] data_q, data_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;

   // Load wins over drain; payload only changes on load.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         count_d = count_i;
         ovf_d   = ovf_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Output register state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign count_o = count_q;
   assign ovf_o   = ovf_q;
endmodule

// File: rtl/fn1_prod_accum.sv
// Sums groups of fn1 multiplier products; a group closes on in_last, MAX_TERMS terms, or flush.
// Latency: closing beat accepted at edge N -> out_valid after edge N. FN1_ACC_SAT_EN: clamp instead of wrap.
// Backpressure: in_ready = ~FULL | out_ready, so a result transfer and a new beat can share a cycle.
module fn1_prod_accum
   import fn1_accum_pkg::*;
#(
   parameter int IN_W      = DEF_IN_W,
   parameter int ACC_W     = DEF_ACC_W,
   parameter int MAX_TERMS = DEF_MAX_TERMS,
   parameter int CNT_W     = cnt_width(MAX_TERMS)
) (
   input  logic             clk,
   input  logic             reset,
   fn1_prod_accum_if.slave  bus
);
   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   logic             in_ready;
   logic             beat;
   logic             partial;
   logic [ACC_W-1:0] base_acc;
   logic [CNT_W-1:0] base_cnt;
   logic [ACC_W:0]   sum_w;
   logic [ACC_W-1:0] sum_val;
   logic [CNT_W-1:0] sum_cnt;
   logic             sum_ovf;
   logic             close_beat;
   logic             flush_only;
   logic             load;
   logic [ACC_W-1:0] ld_data;
   logic [CNT_W-1:0] ld_count;
   logic             ld_ovf;

   assign in_ready = (state_q != FULL) | bus.out_ready;
   assign beat     = bus.in_valid & in_ready;
   assign partial  = (state_q == ACCUM);
   assign base_acc = partial ? acc_q : '0;
   assign base_cnt = partial ? cnt_q : '0;

   // One extra bit catches the carry out of the accumulator.
   assign sum_w   = {1'b0, base_acc} + {{(ACC_W + 1 - IN_W){1'b0}}, bus.in_data};
   assign sum_cnt = base_cnt + CNT_W'(1);
   assign sum_ovf = sum_w[ACC_W] | (partial & ovf_q);

   // Saturating build clamps on carry; once at all-ones it stays there for the group.
   always_comb begin
`ifdef FN1_ACC_SAT_EN
      sum_val = sum_w[ACC_W] ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
      sum_val = sum_w[ACC_W-1:0];
`endif
   end

   assign close_beat = bus.in_last | (sum_cnt == CNT_W'(MAX_TERMS)) | bus.flush;
   assign flush_only = ~beat & bus.flush & partial;

   // Next state, accumulator update and result load.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      load     = 1'b0;
      ld_data  = sum_val;
      ld_count = sum_cnt;
      ld_ovf   = sum_ovf;
      if (beat) begin
         if (close_beat) begin
            load    = 1'b1;
            state_d = FULL;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
         end else begin
            state_d = ACCUM;
            acc_d   = sum_val;
            cnt_d   = sum_cnt;
            ovf_d   = sum_ovf;
         end
      end else if (flush_only) begin
         load     = 1'b1;
         ld_data  = acc_q;
         ld_count = cnt_q;
         ld_ovf   = ovf_q;
         state_d  = FULL;
         acc_d    = '0;
         cnt_d    = '0;
         ovf_d    = 1'b0;
      end else if ((state_q == FULL) && bus.out_ready) begin
         state_d = IDLE;
      end
   end

   // FSM and partial-sum registers; reset drops any partial group.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   fn1_accum_out_reg #(
      .ACC_W (ACC_W),
      .CNT_W (CNT_W)
   ) u_out_reg (
      .clk     (clk),
      .reset   (reset),
      .load_i  (load),
      .data_i  (ld_data),
      .count_i (ld_count),
      .ovf_i   (ld_ovf),
      .ready_i (bus.out_ready),
      .valid_o (bus.out_valid),
      .data_o  (bus.out_data),
      .count_o (bus.out_count),
      .ovf_o   (bus.out_ovf)
   );

   assign bus.in_ready = in_ready;
endmodule

// File: tb/tb_fn1_prod_accum.sv
// Bench for fn1_prod_accum: three instances (default, MAX_TERMS=4, ACC_W=31) share one stimulus stream.
// Latency: n/a.
// Backpressure: out_ready is driven low in bursts; each instance's reference model tracks its own acceptance.
module tb_fn1_prod_accum;
   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [30:0] in_data;
   logic        in_last;
   logic        flush;
   logic        out_ready;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int AW = (g == 2) ? 31 : 40;
      localparam int MT = (g == 1) ? 4 : 256;
      localparam int CW = $clog2(MT + 1);

      fn1_prod_accum_if #(.IN_W(31), .ACC_W(AW), .CNT_W(CW)) bus ();

      assign bus.in_valid  = in_valid;
      assign bus.in_data   = in_data;
      assign bus.in_last   = in_last;
      assign bus.flush     = flush;
      assign bus.out_ready = out_ready;

      fn1_prod_accum #(.IN_W(31), .ACC_W(AW), .MAX_TERMS(MT), .CNT_W(CW)) u_dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus)
      );

      // Transaction-level reference: an open partial group and at most one pending result.
      initial begin : model
         logic [63:0] lim, acc, pdat, s;
         int          cnt, pcnt, c;
         bit          open, pend, ovf, povf, o, rdy, fire;
         lim  = 64'd1 << AW;
         acc  = 0; pdat = 0; s = 0;
         cnt  = 0; pcnt = 0; c = 0;
         open = 0; pend = 0; ovf = 0; povf = 0;
         forever begin
            @(negedge clk);
            if (reset) begin
               open = 0; pend = 0; acc = 0; cnt = 0; ovf = 0;
               chk($sformatf("u%0d.rst_valid", g), 64'(bus.out_valid), 64'd0);
               chk($sformatf("u%0d.rst_data", g),  64'(bus.out_data),  64'd0);
               chk($sformatf("u%0d.rst_count", g), 64'(bus.out_count), 64'd0);
               chk($sformatf("u%0d.rst_ovf", g),   64'(bus.out_ovf),   64'd0);
               chk($sformatf("u%0d.rst_ready", g), 64'(bus.in_ready),  64'd1);
            end else begin
               rdy = !pend || out_ready;
               chk($sformatf("u%0d.in_ready", g),  64'(bus.in_ready),  64'(rdy));
               chk($sformatf("u%0d.out_valid", g), 64'(bus.out_valid), 64'(pend));
               if (pend) begin
                  chk($sformatf("u%0d.out_data", g),  64'(bus.out_data),  pdat);
                  chk($sformatf("u%0d.out_count", g), 64'(bus.out_count), 64'(pcnt));
                  chk($sformatf("u%0d.out_ovf", g),   64'(bus.out_ovf),   64'(povf));
               end
               fire = in_valid && rdy;
               if (pend && out_ready) pend = 0;
               if (fire) begin
                  s = (open ? acc : 64'd0) + 64'(in_data);
                  c = (open ? cnt : 0) + 1;
                  o = open && ovf;
                  if (s >= lim) begin
                     o = 1;
`ifdef FN1_ACC_SAT_EN
                     s = lim - 1;
`else
                     s = s - lim;
`endif
                  end
                  if (in_last || c == MT || flush) begin
                     pend = 1; pdat = s; pcnt = c; povf = o; open = 0;
                  end else begin
                     open = 1; acc = s; cnt = c; ovf = o;
                  end
               end else if (flush && open) begin
                  pend = 1; pdat = acc; pcnt = cnt; povf = ovf; open = 0;
               end
            end
         end
      end
   end

   task automatic drive(input logic v, input logic [30:0] d, input logic l, input logic f);
      in_valid = v;
      in_data  = d;
      in_last  = l;
      flush    = f;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 31'd0, 1'b0, 1'b0);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Three-beat group; result visible right after the closing edge.
      drive(1'b1, 31'd100, 1'b0, 1'b0);
      drive(1'b1, 31'd200, 1'b0, 1'b0);
      drive(1'b1, 31'd300, 1'b1, 1'b0);
      chk("t1.data",  64'(g_dut[0].bus.out_data),  64'd600);
      chk("t1.count", 64'(g_dut[0].bus.out_count), 64'd3);
      chk("t1.ovf",   64'(g_dut[0].bus.out_ovf),   64'd0);
      idle(2);

      // Six unit beats: instance 1 closes at four terms, then flush closes the remaining two.
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 31'd1, 1'b0, 1'b0);
         if (i == 3) begin
            chk("t2.data",  64'(g_dut[1].bus.out_data),  64'd4);
            chk("t2.count", 64'(g_dut[1].bus.out_count), 64'd4);
         end
      end
      idle(1);
      drive(1'b0, 31'd0, 1'b0, 1'b1);
      chk("t2.flush_data",  64'(g_dut[1].bus.out_data),  64'd2);
      chk("t2.flush_count", 64'(g_dut[1].bus.out_count), 64'd2);
      idle(2);

      // Backpressure: result held, waiting beat stalls, then both move in one cycle.
      drive(1'b1, 31'd7, 1'b1, 1'b0);
      out_ready = 1'b0;
      repeat (4) drive(1'b1, 31'd9, 1'b1, 1'b0);
      out_ready = 1'b1;
      drive(1'b1, 31'd9, 1'b1, 1'b0);
      chk("t3.data", 64'(g_dut[0].bus.out_data), 64'd9);
      idle(2);

      // Carry out of a 31-bit accumulator.
      drive(1'b1, 31'h7FFF_FFFF, 1'b0, 1'b0);
      drive(1'b1, 31'd2, 1'b1, 1'b0);
`ifdef FN1_ACC_SAT_EN
      chk("t4.data", 64'(g_dut[2].bus.out_data), 64'h7FFF_FFFF);
`else
      chk("t4.data", 64'(g_dut[2].bus.out_data), 64'd1);
`endif
      chk("t4.ovf", 64'(g_dut[2].bus.out_ovf), 64'd1);
      idle(2);

      // Reset mid-group drops the partial sum.
      drive(1'b1, 31'd3, 1'b0, 1'b0);
      drive(1'b1, 31'd4, 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      chk("t5.rst_valid", 64'(g_dut[0].bus.out_valid), 64'd0);
      chk("t5.rst_data",  64'(g_dut[0].bus.out_data),  64'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      drive(1'b1, 31'd5, 1'b1, 1'b0);
      chk("t5.data",  64'(g_dut[0].bus.out_data),  64'd5);
      chk("t5.count", 64'(g_dut[0].bus.out_count), 64'd1);
      idle(2);

      // Flush while idle, then flush together with in_last.
      drive(1'b0, 31'd0, 1'b0, 1'b1);
      chk("t6.idle_flush", 64'(g_dut[0].bus.out_valid), 64'd0);
      idle(1);
      drive(1'b1, 31'd8, 1'b1, 1'b1);
      idle(3);

      // Randomized traffic with bursts of backpressure.
      for (int i = 0; i < 3000; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         drive($urandom_range(0, 3) != 0,
               ($urandom_range(0, 1) != 0) ? 31'($urandom) : 31'($urandom_range(0, 1000)),
               $urandom_range(0, 5) == 0,
               $urandom_range(0, 9) == 0);
      end
      out_ready = 1'b1;
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
